flag_sched: RTL and testbench

- Write scheduler for the single-bit F flag register of the 3-bit Forth core.
- Arbitrates flag-write requests from NREQ producers (ALU compare, stack-unit under/overflow, I/O status) with round-robin priority.
- Drives the flag register's load-data and load-enable inputs.
- Gives the branch unit a bounded "lock" window in which F is guaranteed stable between test and branch.

---
 rtl/flag_pkg.sv | 23 ++
 rtl/flag_rr_pick.sv | 34 +++
 rtl/flag_sched.sv | 96 +++++++++
 tb/tb_flag_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared types and constants for the F-flag write scheduler and related write arbiters.
package flag_pkg;

  localparam int NREQ_DEF     = 3;
  localparam int LOCK_MAX_DEF = 4;
  localparam int LOCK_CW      = 4;

  // Requester slots of the Forth core's flag producers
  localparam int REQ_ALU = 0;
  localparam int REQ_STK = 1;
  localparam int REQ_IO  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/flag_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module flag_rr_pick
  import flag_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int pos;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    // Scan from the farthest slot back to ptr so the nearest hit is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        any = 1'b1;
        idx = IW'(pos);
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/flag_sched.sv
// Round-robin write scheduler for the F flag with a bounded branch lock window.
// Define FLAG_SCHED_PRIO0_EN to give requester 0 absolute priority over the round-robin.
module flag_sched
  import flag_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] val,
  output logic [NREQ-1:0] gnt,
  output logic            f_in,
  output logic            f_f,
  input  logic            lock_req,
  output logic            lock_gnt,
  output logic            lock_err,
  output logic            busy
);

  localparam int IW = $clog2(NREQ);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [LOCK_CW-1:0]  lock_cnt;

  logic [NREQ-1:0]     rr_onehot;
  logic [IW-1:0]       rr_idx;
  logic                rr_any;
  logic                prio0_hit;
  logic [NREQ-1:0]     sel_onehot;
  logic [IW-1:0]       sel_idx;
  logic                force_off;
  logic                lock_take;

  flag_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

`ifdef FLAG_SCHED_PRIO0_EN
  assign prio0_hit = req[REQ_ALU];
`else
  assign prio0_hit = 1'b0;
`endif

  assign sel_onehot = prio0_hit ? (NREQ'(1) << REQ_ALU) : rr_onehot;
  assign sel_idx    = prio0_hit ? IW'(REQ_ALU) : rr_idx;

  // The edge that ends the LOCK_MAX-th lock cycle ignores lock_req, letting one write through.
  assign force_off = (state == LOCK) && (lock_cnt == LOCK_CW'(LOCK_MAX));
  assign lock_take = lock_req && !force_off;

  // NOTE: all state and outputs use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_cnt <= '0;
      gnt      <= '0;
      f_in     <= 1'b0;
      f_f      <= 1'b0;
      lock_gnt <= 1'b0;
      lock_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt      <= '0;
      f_in     <= 1'b0;
      f_f      <= 1'b0;
      lock_gnt <= 1'b0;
      busy     <= lock_take || rr_any;
      if (lock_take) begin
        state    <= LOCK;
        lock_gnt <= 1'b1;
        lock_cnt <= (state == LOCK) ? lock_cnt + LOCK_CW'(1) : LOCK_CW'(1);
      end else begin
        lock_cnt <= '0;
        if (force_off) lock_err <= 1'b1;
        if (rr_any) begin
          state <= WRITE;
          gnt   <= sel_onehot;
          f_f   <= 1'b1;
          f_in  <= val[sel_idx];
          if (!prio0_hit) ptr <= IW'(wrap_inc(int'(rr_idx), NREQ));
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_sched.sv
// Self-checking bench for flag_sched: directed scenarios plus randomized traffic against a reference model.
module tb_flag_sched;

  localparam int NREQ     = 3;
  localparam int LOCK_MAX = 4;
`ifdef FLAG_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req, val, gnt;
  logic            f_in, f_f, lock_req, lock_gnt, lock_err, busy;
  logic            flag_q = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and its expected outputs
  int              m_ptr, m_cnt;
  bit              m_lock, m_err;
  logic [NREQ-1:0] e_gnt;
  logic            e_fin, e_ff, e_lock, e_busy;

  flag_sched #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .val      (val),
    .gnt      (gnt),
    .f_in     (f_in),
    .f_f      (f_f),
    .lock_req (lock_req),
    .lock_gnt (lock_gnt),
    .lock_err (lock_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // The flag register itself loads mid-cycle
  always @(negedge clk) if (f_f === 1'b1) flag_q <= f_in;

  always @(posedge clk) begin
    int  w;
    bit  forced;
    e_gnt = '0; e_fin = 1'b0; e_ff = 1'b0; e_lock = 1'b0;
    if (!rst_n) begin
      m_ptr = 0; m_cnt = 0; m_lock = 0; m_err = 0;
    end else begin
      forced = m_lock && (m_cnt == LOCK_MAX);
      if (lock_req && !forced) begin
        m_cnt  = m_lock ? m_cnt + 1 : 1;
        m_lock = 1;
        e_lock = 1'b1;
      end else begin
        if (forced) m_err = 1;
        m_lock = 0;
        m_cnt  = 0;
        w = -1;
        if (PRIO0 && req[0]) w = 0;
        else
          for (int k = NREQ - 1; k >= 0; k--)
            if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        if (w >= 0) begin
          e_gnt = '0;
          e_gnt[w] = 1'b1;
          e_ff  = 1'b1;
          e_fin = val[w];
          if (!(PRIO0 && w == 0)) m_ptr = (w + 1) % NREQ;
        end
      end
    end
    e_busy = e_lock | e_ff;
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; val = '0; lock_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; val = 3'b111; lock_req = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if ({gnt, f_in, f_f, lock_gnt, lock_err, busy} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", {gnt, f_in, f_f, lock_gnt, lock_err, busy}, 8'b0);
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if ({gnt, f_f, f_in} !== 5'b001_1_1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b f_f=%b f_in=%b expected gnt=001 f_f=1 f_in=1", gnt, f_f, f_in);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_seq [4];
    logic [NREQ-1:0] v_prev;
    int              wi;
    if (PRIO0) exp_seq = '{3'b001, 3'b010, 3'b001, 3'b100};
    else       exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      val = NREQ'($urandom);
      v_prev = val;
      cycle();
      wi = (exp_seq[i] == 3'b001) ? 0 : (exp_seq[i] == 3'b010) ? 1 : 2;
      n_checks++;
      if (gnt !== exp_seq[i] || f_f !== 1'b1 || f_in !== v_prev[wi]) begin
        n_fail++;
        $display("FAIL rr_step%0d: got gnt=%b f_f=%b f_in=%b expected gnt=%b f_f=1 f_in=%b",
                 i, gnt, f_f, f_in, exp_seq[i], v_prev[wi]);
      end
      req = 3'b111 & ~exp_seq[i];
    end
    req = '0;
    cycle();
  endtask

  task automatic test_single_write();
    apply_reset();
    req = 3'b010; val = 3'b010;
    cycle();
    n_checks++;
    if ({gnt, f_f, f_in} !== 5'b010_1_1) begin
      n_fail++;
      $display("FAIL single_write: got gnt=%b f_f=%b f_in=%b expected gnt=010 f_f=1 f_in=1", gnt, f_f, f_in);
    end
    req = '0;
    #1;
    n_checks++;
    if (flag_q !== 1'b1) begin
      n_fail++;
      $display("FAIL single_write_flag: got F=%b expected 1", flag_q);
    end
    cycle();
    n_checks++;
    if ({gnt, f_f, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_write_idle: got gnt=%b f_f=%b busy=%b expected 0", gnt, f_f, busy);
    end
  endtask

  task automatic test_lock_vs_write();
    apply_reset();
    lock_req = 1'b1; req = 3'b001; val = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({lock_gnt, f_f, gnt, busy} !== 6'b1_0_000_1) begin
        n_fail++;
        $display("FAIL lock_hold%0d: got lock_gnt=%b f_f=%b gnt=%b busy=%b expected 1 0 000 1",
                 i, lock_gnt, f_f, gnt, busy);
      end
    end
    lock_req = 1'b0;
    cycle();
    n_checks++;
    if ({lock_gnt, gnt, f_f, lock_err} !== 6'b0_001_1_0) begin
      n_fail++;
      $display("FAIL lock_release_write: got lock_gnt=%b gnt=%b f_f=%b lock_err=%b expected 0 001 1 0",
               lock_gnt, gnt, f_f, lock_err);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_forced_release();
    int lock_cycles = 0;
    apply_reset();
    lock_req = 1'b1; req = 3'b010; val = 3'b010;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      if (lock_gnt === 1'b1 && gnt === 3'b000) lock_cycles++;
    end
    cycle();
    n_checks++;
    if (lock_cycles != 4) begin
      n_fail++;
      $display("FAIL forced_lock_len: got %0d locked cycles expected 4", lock_cycles);
    end
    n_checks++;
    if ({lock_gnt, lock_err, gnt, f_f, f_in} !== 7'b0_1_010_1_1) begin
      n_fail++;
      $display("FAIL forced_exit: got lock_gnt=%b lock_err=%b gnt=%b f_f=%b f_in=%b expected 0 1 010 1 1",
               lock_gnt, lock_err, gnt, f_f, f_in);
    end
    req = '0;
    for (int c = 6; c <= 9; c++) begin
      cycle();
      n_checks++;
      if ({lock_gnt, lock_err} !== 2'b11) begin
        n_fail++;
        $display("FAIL relock_c%0d: got lock_gnt=%b lock_err=%b expected 1 1", c, lock_gnt, lock_err);
      end
    end
    cycle();
    n_checks++;
    if ({lock_gnt, lock_err, gnt} !== 5'b0_1_000) begin
      n_fail++;
      $display("FAIL forced_exit2: got lock_gnt=%b lock_err=%b gnt=%b expected 0 1 000", lock_gnt, lock_err, gnt);
    end
    lock_req = 1'b0;
    cycle();
    n_checks++;
    if ({lock_gnt, lock_err, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL err_sticky: got lock_gnt=%b lock_err=%b busy=%b expected 0 1 0", lock_gnt, lock_err, busy);
    end
  endtask

  task automatic test_prio0();
    logic [NREQ-1:0] exp_g;
    apply_reset();
    req = 3'b101; val = 3'b100;
    for (int i = 0; i < 6; i++) begin
      cycle();
      exp_g = (PRIO0 || (i % 2 == 0)) ? 3'b001 : 3'b100;
      n_checks++;
      if (gnt !== exp_g || f_in !== exp_g[2]) begin
        n_fail++;
        $display("FAIL prio0_step%0d: got gnt=%b f_in=%b expected gnt=%b f_in=%b", i, gnt, f_in, exp_g, exp_g[2]);
      end
    end
    req = '0;
    cycle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (e_gnt[r]) req[r] = 1'b0;
        else if (!req[r]) req[r] = 1'($urandom_range(0, 1));
      end
      val   = NREQ'($urandom);
      if ($urandom_range(0, 7) == 0) lock_req = ~lock_req;
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
      n_checks++;
      if ({gnt, f_in, f_f, lock_gnt, lock_err, busy} !== {e_gnt, e_fin, e_ff, e_lock, m_err, e_busy}) begin
        n_fail++;
        $display("FAIL random_c%0d: got gnt=%b f_in=%b f_f=%b lock_gnt=%b lock_err=%b busy=%b expected %b %b %b %b %b %b",
                 i, gnt, f_in, f_f, lock_gnt, lock_err, busy, e_gnt, e_fin, e_ff, e_lock, m_err, e_busy);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; val = '0; lock_req = 1'b0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_lock_vs_write();
    test_forced_release();
    test_prio0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
